// File: rtl/mac_sequencer.sv
// Sequencer driving an alu2 multiply-accumulate stage. Streams operand pairs in,
// issues REGA/REGB/MULT/ACC per pair, and reports the per-job accumulator delta.
module mac_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      a_reset_n,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      len,
  output logic                      busy,
  input  logic [DATA_WIDTH-1:0]     op_a,
  input  logic [DATA_WIDTH-1:0]     op_b,
  input  logic                      op_valid,
  output logic                      op_ready,
  output logic [3:0]                alu_opcode,
  output logic [DATA_WIDTH-1:0]     alu_data,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  output logic [2*DATA_WIDTH-1:0]   res_data,
  output logic                      res_valid,
  input  logic                      res_ready
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_REGA  = 4'h1;
  localparam logic [3:0] OP_REGB  = 4'h2;
  localparam logic [3:0] OP_MULT  = 4'h3;
  localparam logic [3:0] OP_ACC   = 4'h4;
  localparam logic [3:0] OP_MSB   = 4'h5;
  localparam logic [3:0] OP_LSB   = 4'h6;
  localparam logic [3:0] OP_RESET = 4'h7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_OP,
    S_LD_A,
    S_LD_B,
    S_MULT,
    S_ACC,
    S_RD_MSB,
    S_RD_LSB,
    S_CAP_LSB,
    S_RESULT
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [LEN_WIDTH-1:0]      r_count;
  logic [DATA_WIDTH-1:0]     r_a;
  logic [DATA_WIDTH-1:0]     r_b;
  logic [DATA_WIDTH-1:0]     r_msb;
  logic [2*DATA_WIDTH-1:0]   r_base;
  logic [2*DATA_WIDTH-1:0]   r_res_data;
  logic [2*DATA_WIDTH-1:0]   w_acc_now;

  // alu2 presents the LSB during CAP_LSB, completing the accumulator snapshot.
  assign w_acc_now = {r_msb, alu_result};
  assign res_data  = r_res_data;

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Outputs decode r_state and data registers only; inputs affect next state alone.
  always_comb begin
    w_state_next = r_state;
    alu_opcode   = OP_NOP;
    alu_data     = '0;
    busy         = 1'b1;
    op_ready     = 1'b0;
    res_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = (len == '0) ? S_RD_MSB : S_WAIT_OP;
        end
      end
      S_WAIT_OP: begin
        op_ready = 1'b1;
        if (op_valid) begin
          w_state_next = S_LD_A;
        end
      end
      S_LD_A: begin
        alu_opcode   = OP_REGA;
        alu_data     = r_a;
        w_state_next = S_LD_B;
      end
      S_LD_B: begin
        alu_opcode   = OP_REGB;
        alu_data     = r_b;
        w_state_next = S_MULT;
      end
      S_MULT: begin
        alu_opcode   = OP_MULT;
        w_state_next = S_ACC;
      end
      S_ACC: begin
        alu_opcode   = OP_ACC;
        w_state_next = (r_count == LEN_WIDTH'(1)) ? S_RD_MSB : S_WAIT_OP;
      end
      S_RD_MSB: begin
        alu_opcode   = OP_MSB;
        w_state_next = S_RD_LSB;
      end
      S_RD_LSB: begin
        alu_opcode   = OP_LSB;
        w_state_next = S_CAP_LSB;
      end
      S_CAP_LSB: begin
        alu_opcode   = OP_RESET;
        w_state_next = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      r_count    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_msb      <= '0;
      r_base     <= '0;
      r_res_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count <= len;
          end
        end
        S_WAIT_OP: begin
          if (op_valid) begin
            r_a <= op_a;
            r_b <= op_b;
          end
        end
        S_ACC: begin
          r_count <= r_count - LEN_WIDTH'(1);
        end
        S_RD_LSB: begin
          r_msb <= alu_result;
        end
        S_CAP_LSB: begin
          // Accumulator is never cleared, so the job result is the delta from the last snapshot.
          r_res_data <= w_acc_now - r_base;
          r_base     <= w_acc_now;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with a behavioural alu2 model; table-driven jobs plus
// hand-written sequences for opcode order, len=0, stalls and mid-job reset.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        a_reset_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        busy;
  logic [7:0]  op_a = 8'd0;
  logic [7:0]  op_b = 8'd0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_data;
  logic [7:0]  alu_result;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b0;

  always #5 clk = ~clk;

  mac_sequencer #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk        (clk),
    .a_reset_n  (a_reset_n),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .alu_opcode (alu_opcode),
    .alu_data   (alu_data),
    .alu_result (alu_result),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  // Behavioural alu2: registered operands, product, wrapping accumulator and readback.
  logic [7:0]  m_a, m_b, m_dout;
  logic [15:0] m_prod, m_acc;
  assign alu_result = m_dout;

  always @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      m_a <= 8'd0; m_b <= 8'd0; m_dout <= 8'd0; m_prod <= 16'd0; m_acc <= 16'd0;
    end else begin
      case (alu_opcode)
        4'h1: m_a <= alu_data;
        4'h2: m_b <= alu_data;
        4'h3: m_prod <= 16'(m_a) * 16'(m_b);
        4'h4: m_acc <= m_acc + m_prod;
        4'h5: m_dout <= m_acc[15:8];
        4'h6: m_dout <= m_acc[7:0];
        4'h7: begin m_a <= 8'd0; m_b <= 8'd0; m_prod <= 16'd0; end
        default: ;
      endcase
    end
  end

  // Per-cycle trace, only written here; the test reads it from a recorded base index.
  logic [3:0] tr_op[$];
  logic [7:0] tr_dat[$];
  logic       tr_rv[$];
  logic       tr_rdy[$];
  bit         rec_en = 1'b0;

  always @(negedge clk) begin
    if (rec_en) begin
      tr_op.push_back(alu_opcode);
      tr_dat.push_back(alu_data);
      tr_rv.push_back(res_valid);
      tr_rdy.push_back(op_ready);
    end
  end

  typedef struct {
    logic [7:0]       len;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [15:0]      expv;
    int               hold;
    bit               pulse;
    bit               chk_acc;
    logic [15:0]      acc;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] sb_q[$];
  int          tr_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd0);
    chk({tag, "_opcode"}, 32'(alu_opcode), 32'd0);
    chk({tag, "_alu_data"}, 32'(alu_data), 32'd0);
    chk({tag, "_res_data"}, 32'(res_data), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    a_reset_n = 1'b0;
    #2;
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    a_reset_n = 1'b1;
  endtask

  task automatic do_job(input vec_t v, input bit rec);
    logic [15:0] first;
    logic [15:0] e;
    int t;
    sb_q.push_back(v.expv);
    @(posedge clk); #1;
    start = 1'b1; len = v.len;
    @(posedge clk); #1;
    start = 1'b0; len = 8'($urandom);
    if (rec) begin
      tr_base = tr_op.size();
      rec_en  = 1'b1;
    end
    for (int i = 0; i < int'(v.len); i++) begin
      op_a = v.a[i]; op_b = v.b[i]; op_valid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!op_ready && t < 100);
      if (!op_ready) chk("op_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    op_valid = 1'b0; op_a = 8'd0; op_b = 8'd0;
    t = 0;
    do begin @(negedge clk); t++; end while (!res_valid && t < 100);
    chk("res_valid_seen", 32'(res_valid), 32'd1);
    first = res_data;
    for (int k = 0; k < v.hold; k++) begin
      @(posedge clk); #1;
      if (v.pulse) begin start = 1'b1; len = 8'd3; end
      @(negedge clk);
      chk("res_hold_valid", 32'(res_valid), 32'd1);
      chk("res_hold_data", 32'(res_data), 32'(first));
      chk("res_hold_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    start = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("sb_unexpected_result", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      $display("[TB] job len=%0d result=0x%04h expected=0x%04h", v.len, res_data, e);
      chk("sb_result", 32'(res_data), 32'(e));
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", 32'(res_valid), 32'd0);
    chk("post_hs_busy", 32'(busy), 32'd0);
    chk("post_hs_data", 32'(res_data), 32'(v.expv));
    rec_en = 1'b0;
  endtask

  vec_t tbl[5];
  vec_t hv;
  int   idx[$];
  int   t;

  initial begin
    tbl[0] = '{len:8'd1, a:{8'd0,8'd0,8'd0,8'd255}, b:{8'd0,8'd0,8'd0,8'd255},
               expv:16'hFE01, hold:0, pulse:1'b0, chk_acc:1'b1, acc:16'hF804};
    tbl[1] = '{len:8'd0, a:'0, b:'0, expv:16'h0000, hold:2, pulse:1'b1, chk_acc:1'b0, acc:16'h0};
    tbl[2] = '{len:8'd1, a:{8'd0,8'd0,8'd0,8'd10}, b:{8'd0,8'd0,8'd0,8'd10},
               expv:16'h0064, hold:1, pulse:1'b0, chk_acc:1'b0, acc:16'h0};
    tbl[3] = '{len:8'd2, a:{8'd0,8'd0,8'd4,8'd2}, b:{8'd0,8'd0,8'd5,8'd3},
               expv:16'h001A, hold:0, pulse:1'b0, chk_acc:1'b0, acc:16'h0};
    tbl[4] = '{len:8'd4, a:{8'd17,8'd200,8'd3,8'd1}, b:{8'd19,8'd100,8'd4,8'd2},
               expv:16'h4F71, hold:0, pulse:1'b0, chk_acc:1'b0, acc:16'h0};

    #2 a_reset_n = 1'b0;
    #1 chk_reset_outputs("init");
    repeat (2) @(posedge clk);
    #1 a_reset_n = 1'b1;

    // len=1 (3,4): exact opcode/data sequence and a held result.
    hv = '{len:8'd1, a:{8'd0,8'd0,8'd0,8'd3}, b:{8'd0,8'd0,8'd0,8'd4},
           expv:16'h000C, hold:3, pulse:1'b0, chk_acc:1'b0, acc:16'h0};
    do_job(hv, 1'b1);
    chk("seq1_len", 32'(tr_op.size() - tr_base >= 9), 32'd1);
    for (int k = 0; k < 9; k++) begin
      logic [3:0] eo;
      logic [7:0] ed;
      eo = (k == 0 || k == 8) ? 4'd0 : 4'(k);
      ed = (k == 1) ? 8'd3 : (k == 2) ? 8'd4 : 8'd0;
      chk($sformatf("seq1_opcode[%0d]", k), 32'(tr_op[tr_base + k]), 32'(eo));
      chk($sformatf("seq1_data[%0d]", k), 32'(tr_dat[tr_base + k]), 32'(ed));
    end
    chk("seq1_rv_before", 32'(tr_rv[tr_base + 7]), 32'd0);
    chk("seq1_rv_at", 32'(tr_rv[tr_base + 8]), 32'd1);

    // len=0: only readback opcodes, result 3 edges after start, start pulses ignored.
    hv = '{len:8'd0, a:'0, b:'0, expv:16'h0000, hold:10, pulse:1'b1, chk_acc:1'b0, acc:16'h0};
    do_job(hv, 1'b1);
    t = 0;
    for (int k = tr_base; k < tr_op.size(); k++)
      if (tr_op[k] >= 4'd1 && tr_op[k] <= 4'd4) t++;
    chk("len0_no_pair_ops", 32'(t), 32'd0);
    chk("len0_first_op", 32'(tr_op[tr_base]), 32'd5);
    chk("len0_rv_at3", 32'(tr_rv[tr_base + 3]), 32'd1);
    chk("len0_rv_at2", 32'(tr_rv[tr_base + 2]), 32'd0);

    // Fresh accumulator, then 3x(255,255) with op_valid held high.
    apply_reset();
    hv = '{len:8'd3, a:{8'd0,8'd255,8'd255,8'd255}, b:{8'd0,8'd255,8'd255,8'd255},
           expv:16'hFA03, hold:0, pulse:1'b0, chk_acc:1'b0, acc:16'h0};
    do_job(hv, 1'b1);
    t = 0;
    idx.delete();
    for (int k = tr_base; k < tr_op.size(); k++) begin
      if (tr_rdy[k]) t++;
      if (tr_op[k] == 4'd1) idx.push_back(k);
    end
    chk("fa03_op_ready_cycles", 32'(t), 32'd3);
    chk("fa03_rega_count", 32'(idx.size()), 32'd3);
    if (idx.size() == 3) begin
      chk("fa03_spacing01", 32'(idx[1] - idx[0]), 32'd5);
      chk("fa03_spacing12", 32'(idx[2] - idx[1]), 32'd5);
    end

    for (int i = 0; i < 5; i++) begin
      do_job(tbl[i], 1'b0);
      if (tbl[i].chk_acc) chk($sformatf("tbl%0d_alu_acc", i), 32'(m_acc), 32'(tbl[i].acc));
    end

    // Reset asserted mid-job while waiting for the second pair.
    @(posedge clk); #1;
    start = 1'b1; len = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; op_a = 8'd9; op_b = 8'd9; op_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!op_ready && t < 100);
    @(posedge clk); #1;
    op_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!op_ready && t < 100);
    chk("midjob_in_wait_op", 32'(op_ready), 32'd1);
    chk("midjob_busy", 32'(busy), 32'd1);
    #2 a_reset_n = 1'b0;
    #1 chk_reset_outputs("midjob");
    @(posedge clk); #1;
    a_reset_n = 1'b1;
    hv = '{len:8'd1, a:{8'd0,8'd0,8'd0,8'd7}, b:{8'd0,8'd0,8'd0,8'd6},
           expv:16'h002A, hold:0, pulse:1'b0, chk_acc:1'b0, acc:16'h0};
    do_job(hv, 1'b0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
